// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer
//   Replays a small program RAM into the CPU instruction port. The host writes
//   up to DEPTH 16-bit words and then pulses start. For each word the sequencer
//   presents it on cpu_in, pulses cpu_load, pulses cpu_s, and then waits for
//   cpu_w to go low (the CPU has accepted the instruction) and high again (the
//   CPU has finished executing it).
//
//   All outputs are registered. The load, s and done pulses therefore appear
//   in the cycle after the corresponding state, and cpu_in holds its value
//   until the next word is loaded.
//
//   Optional feature macro: WDOG_EN. When it is defined, a per-wait-phase
//   watchdog aborts the run into ERR after WDOG_CYCLES cycles. When it is not
//   defined, err is tied low and the wait states wait indefinitely.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   prog_we    program write strobe, ignored while busy
//   prog_addr  program write address
//   prog_data  program write data (instruction word)
//   start      starts a run, ignored while busy
//   count      number of instructions to run (0..DEPTH), sampled when start is accepted
//   cpu_w      CPU wait flag (1 = CPU idle)
//   cpu_in     instruction word driven to the CPU
//   cpu_load   one-cycle pulse that loads the CPU instruction register
//   cpu_s      one-cycle pulse that starts CPU execution
//   pc         index of the instruction in flight
//   busy       high while a run is in progress
//   done       one-cycle pulse after the last instruction completes
//   err        watchdog timeout, sticky until the next accepted start
module cpu_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
`ifdef WDOG_EN
  ,
  parameter int WDOG_CYCLES = 255
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   count,
  input  logic          cpu_w,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
    DONE,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   cpu_in_q;
  logic          load_q, s_q, done_q;
  logic          accept;
  logic          last;

  logic [15:0]   mem [DEPTH];

  assign busy   = (state_q != IDLE);
  assign accept = (state_q == IDLE) && start;
  // The comparison is done at AW+1 bits so that count == DEPTH terminates on
  // pc == DEPTH-1 without pc ever wrapping.
  assign last   = (({1'b0, pc_q} + (AW+1)'(1)) == count_q);

`ifdef WDOG_EN
  logic [7:0] wdog_q;
  logic       wdog_hit;
  logic       err_q;

  assign wdog_hit = (wdog_q == 8'(WDOG_CYCLES - 1));
`endif

  // NOTE: every variable is given a default value first, so that no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          count_d = count;
          state_d = (count == '0) ? DONE : LOAD;
        end
      end
      LOAD:  state_d = START;
      START: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (!cpu_w) state_d = WAIT_DONE;
`ifdef WDOG_EN
        else if (wdog_hit) state_d = ERR;
`endif
      end
      WAIT_DONE: begin
        if (cpu_w) begin
          if (last) begin
            state_d = DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = LOAD;
          end
        end
`ifdef WDOG_EN
        else if (wdog_hit) state_d = ERR;
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values it had before this clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      cpu_in_q <= '0;
      load_q   <= 1'b0;
      s_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      load_q  <= (state_q == LOAD);
      s_q     <= (state_q == START);
      done_q  <= (state_q == DONE);
      // The RAM is read in LOAD rather than on start, so a word written in
      // the same cycle as an accepted start is the one that gets issued.
      if (state_q == LOAD) cpu_in_q <= mem[pc_q];
    end
  end

  // NOTE: the program RAM has no reset. Its contents are defined only by
  // host writes, and leaving out the reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

`ifdef WDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // Any state change clears the counter, which covers entry into both
      // wait states. The counter only advances while a wait state persists.
      if (state_d != state_q) wdog_q <= '0;
      else if (state_q == WAIT_ACK || state_q == WAIT_DONE) wdog_q <= wdog_q + 8'd1;

      if (accept) err_q <= 1'b0;
      else if (state_q == ERR) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cpu_in   = cpu_in_q;
  assign cpu_load = load_q;
  assign cpu_s    = s_q;
  assign pc       = pc_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb_cpu_instr_sequencer
//   Testbench for cpu_instr_sequencer. A behavioural CPU responder answers each
//   cpu_s pulse with a low-then-high cpu_w handshake of random length. When a
//   run is started, the expected {pc, instruction} pairs are pushed into a
//   queue. Each cpu_load pulse pops one pair and compares it.
module tb_cpu_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic [AW:0]   count;
  logic          cpu_w;
  logic [15:0]   cpu_in;
  logic          cpu_load;
  logic          cpu_s;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

`ifdef WDOG_EN
  cpu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .WDOG_CYCLES(8)) dut (
`else
  cpu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .count     (count),
    .cpu_w     (cpu_w),
    .cpu_in    (cpu_in),
    .cpu_load  (cpu_load),
    .cpu_s     (cpu_s),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [15:0]   instr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          load_cnt = 0;
  int          s_cnt    = 0;
  int          done_cnt = 0;
  logic [15:0] last_loaded = '0;
  bit          cpu_stuck = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CPU responder: it sees s at the negedge, takes the instruction at the
  // next posedge (w falls), and finishes 1..3 cycles later (w rises).
  initial begin
    cpu_w = 1'b1;
    forever begin
      @(negedge clk);
      if (cpu_s === 1'b1 && !cpu_stuck) begin
        @(posedge clk);
        #1 cpu_w = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 cpu_w = 1'b1;
      end
    end
  end

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (cpu_load) begin
        load_cnt++;
        check("load_s_overlap", {31'b0, cpu_s}, 32'd0);
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("load_instr", {16'b0, cpu_in}, {16'b0, e.instr});
          check("load_pc", {28'b0, pc}, {28'b0, e.pc});
        end
        last_loaded = cpu_in;
      end
      if (cpu_s) begin
        s_cnt++;
        check("s_instr_stable", {16'b0, cpu_in}, {16'b0, last_loaded});
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_counts();
    load_cnt = 0;
    s_cnt    = 0;
    done_cnt = 0;
  endtask

  task automatic prog(input int a, input logic [15:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    model_mem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic push_run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = AW'(i);
      e.instr = model_mem[i];
      sb.push_back(e);
    end
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    start = 1'b1;
    count = (AW+1)'(n);
    push_run(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, {31'b0, (cyc >= 2000)}, 32'd0);
    @(negedge clk);
    check({tag, "_loads"}, load_cnt, n);
    check({tag, "_s"}, s_cnt, n);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    count     = '0;

    // Reset state
    #1;
    check("rst_cpu_in", {16'b0, cpu_in}, 32'd0);
    check("rst_load", {31'b0, cpu_load}, 32'd0);
    check("rst_s", {31'b0, cpu_s}, 32'd0);
    check("rst_pc", {28'b0, pc}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single MOV R0,#11
    prog(0, 16'hD00B);
    clear_counts();
    start_run(1);
    wait_done(1, "single");

    // Four MOVs plus ADD R7,R6,R3
    prog(0, 16'hD003);
    prog(1, 16'hD102);
    prog(2, 16'hD306);
    prog(3, 16'hD604);
    prog(4, 16'hA6E3);
    clear_counts();
    start_run(5);
    wait_done(5, "five");

    // count == 0: done on the next cycle, busy for exactly one cycle, no pulses
    clear_counts();
    start_run(0);
    check("zero_busy", {31'b0, busy}, 32'd1);
    check("zero_done_early", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("zero_busy_off", {31'b0, busy}, 32'd0);
    check("zero_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("zero_done_pulse", {31'b0, done}, 32'd0);
    check("zero_loads", load_cnt, 0);
    check("zero_s", s_cnt, 0);

    // Write in the same cycle as an accepted start: the new word is issued
    clear_counts();
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_data = 16'h1234;
    model_mem[0] = 16'h1234;
    start = 1'b1;
    count = (AW+1)'(1);
    push_run(1);
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    wait_done(1, "same_cycle_we");

    // start and prog_we while busy are dropped
    clear_counts();
    start_run(3);
    @(negedge clk);
    start     = 1'b1;
    count     = (AW+1)'(5);
    prog_we   = 1'b1;
    prog_addr = AW'(2);
    prog_data = 16'hFFFF;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    wait_done(3, "busy_drop");
    repeat (4) @(negedge clk);
    check("busy_drop_no_rerun", done_cnt, 1);
    clear_counts();
    start_run(3);
    wait_done(3, "ram_unchanged");

    // Full-depth run: pc must go from 0 up to DEPTH-1 without wrapping
    for (int i = 0; i < DEPTH; i++) prog(i, 16'($urandom));
    clear_counts();
    start_run(DEPTH);
    wait_done(DEPTH, "full");

    // Reset asserted while the DUT is in WAIT_DONE
    clear_counts();
    start_run(2);
    cyc = 0;
    while (cpu_w !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_wait_timeout", {31'b0, (cyc >= 200)}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_load", {31'b0, cpu_load}, 32'd0);
    check("rst_mid_s", {31'b0, cpu_s}, 32'd0);
    check("rst_mid_pc", {28'b0, pc}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", {31'b0, busy}, 32'd0);

    // The sequencer still works after the abandoned run
    clear_counts();
    start_run(2);
    wait_done(2, "post_reset");

`ifdef WDOG_EN
    // Watchdog: the CPU never leaves its wait state
    clear_counts();
    cpu_stuck = 1'b1;
    start_run(1);
    cyc = 0;
    while (err !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("wdog_err", {31'b0, err}, 32'd1);
    check("wdog_busy", {31'b0, busy}, 32'd0);
    check("wdog_pc", {28'b0, pc}, 32'd0);
    repeat (3) @(negedge clk);
    check("wdog_no_done", done_cnt, 0);
    check("wdog_err_sticky", {31'b0, err}, 32'd1);
    cpu_stuck = 1'b0;
    clear_counts();
    start_run(1);
    check("wdog_err_cleared", {31'b0, err}, 32'd0);
    wait_done(1, "wdog_recover");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
